// File: rtl/vga_pattern_timing_gen.sv
// VGA raster timing generator with a selectable 24-bit test pattern.
// One register stage between the raster counters and every output, so hs/vs/de/data/frame_start
// for counter position (h,v) all appear together one clock after the counters hold (h,v).
module vga_pattern_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_color,
    output logic [23:0] vga_data,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // At least 8 bits so the gradient and checkerboard can slice low counter bits directly.
    localparam int HW = ($clog2(H_TOTAL) > 8) ? $clog2(H_TOTAL) : 8;
    localparam int VW = ($clog2(V_TOTAL) > 8) ? $clog2(V_TOTAL) : 8;
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int BW = ($clog2(BAR_W) > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_W - 1);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    // Low for the single cycle after reset release: counters hold (0,0) one extra edge.
    logic          running;
    logic [BW-1:0] bar_px;
    logic [2:0]    bar_idx;
    logic [1:0]    shadow_mode;
    logic [23:0]   shadow_color;

    logic          at_origin;
    logic [1:0]    eff_mode;
    logic [23:0]   eff_color;
    logic          h_act;
    logic          v_act;
    logic          de_c;
    logic          hsync_c;
    logic          vsync_c;
    logic [7:0]    grad_b;
    logic [23:0]   bar_color;
    logic [23:0]   pix;

    // Raster counters plus the bar sub-counter that replaces a divide by BAR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            running <= 1'b0;
            bar_px  <= '0;
            bar_idx <= '0;
        end else if (!running) begin
            running <= 1'b1;
        end else if (h_cnt == H_LAST) begin
            h_cnt   <= '0;
            bar_px  <= '0;
            bar_idx <= '0;
            v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
            if (bar_px == BAR_LAST) begin
                bar_px  <= '0;
                bar_idx <= bar_idx + 3'd1;
            end else begin
                bar_px <= bar_px + 1'b1;
            end
        end
    end

    // Pattern and sync decode for the current counter position.
    always_comb begin
        at_origin = running && (h_cnt == '0) && (v_cnt == '0);
        // The capture at (0,0) must already govern pixel (0,0), so bypass the shadow there.
        eff_mode  = at_origin ? mode : shadow_mode;
        eff_color = at_origin ? solid_color : shadow_color;
        h_act     = h_cnt < H_ACT_END;
        v_act     = v_cnt < V_ACT_END;
        de_c      = h_act && v_act;
        hsync_c   = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        vsync_c   = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        grad_b    = h_cnt[7:0] + v_cnt[7:0];

        bar_color = 24'h000000;
        unique case (bar_idx)
            3'd0: bar_color = 24'hFFFFFF;
            3'd1: bar_color = 24'hFFFF00;
            3'd2: bar_color = 24'h00FFFF;
            3'd3: bar_color = 24'h00FF00;
            3'd4: bar_color = 24'hFF00FF;
            3'd5: bar_color = 24'hFF0000;
            3'd6: bar_color = 24'h0000FF;
            3'd7: bar_color = 24'h000000;
        endcase

        pix = 24'h000000;
        unique case (eff_mode)
            2'd0: pix = bar_color;
            2'd1: pix = {h_cnt[7:0], v_cnt[7:0], grad_b};
            2'd2: pix = eff_color;
            2'd3: pix = (h_cnt[5] ^ v_cnt[5]) ? 24'h000000 : 24'hFFFFFF;
        endcase
    end

    // Pattern settings are frozen for a whole frame, sampled at the raster origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_mode  <= 2'd0;
            shadow_color <= 24'h000000;
        end else if (at_origin) begin
            shadow_mode  <= mode;
            shadow_color <= solid_color;
        end
    end

    // Output register stage; held at idle values until the raster is running.
    always_ff @(posedge clk) begin
        if (rst || !running) begin
            vga_data    <= 24'h000000;
            de          <= 1'b0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            vga_data    <= de_c ? pix : 24'h000000;
            de          <= de_c;
            hs          <= hsync_c ? HS_POL : ~HS_POL;
            vs          <= vsync_c ? VS_POL : ~VS_POL;
            frame_start <= at_origin;
        end
    end

endmodule

// File: tb/tb_vga_pattern_timing_gen.sv
// Self-checking bench for vga_pattern_timing_gen on a reduced raster (80x47 total, 64x40 active).
module tb_vga_pattern_timing_gen;

    localparam int HA = 64;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 4;
    localparam int VA = 40;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [23:0] solid_color;
    logic [23:0] vga_data;
    logic        hs;
    logic        vs;
    logic        de;
    logic        frame_start;

    int n_checks = 0;
    int n_fail   = 0;

    vga_pattern_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .solid_color(solid_color),
        .vga_data(vga_data),
        .hs(hs),
        .vs(vs),
        .de(de),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] bar_of(input int h);
        case (h / (HA / 8))
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Behavioural model: edges since release give the raster position directly.
    int          k = 0;
    int          pos, mh, mv, fno;
    logic [1:0]  sm = 2'd0;
    logic [23:0] sc = 24'h0;
    logic [23:0] e_data;
    logic        e_de, e_hs, e_vs, e_fs;

    always @(posedge clk) begin
        if (rst) begin
            k = 0;
            sm = 2'd0;
            sc = 24'h0;
            fno = 0;
            mh = -1;
            mv = -1;
            {e_data, e_de, e_hs, e_vs, e_fs} = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        end else begin
            k++;
            if (k == 1) begin
                mh = -1;
                mv = -1;
                {e_data, e_de, e_hs, e_vs, e_fs} = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0};
            end else begin
                pos = (k - 2) % FR;
                mh  = pos % HT;
                mv  = pos / HT;
                if (pos == 0) begin
                    sm  = mode;
                    sc  = solid_color;
                    fno = (k - 2) / FR;
                end
                e_de = (mh < HA) && (mv < VA);
                e_hs = !((mh >= HA + HF) && (mh < HA + HF + HS));
                e_vs = !((mv >= VA + VF) && (mv < VA + VF + VS));
                e_fs = (pos == 0);
                case (sm)
                    2'd0: e_data = bar_of(mh);
                    2'd1: e_data = {8'(mh % 256), 8'(mv % 256), 8'((mh + mv) % 256)};
                    2'd2: e_data = sc;
                    default: e_data = ((mh / 32 + mv / 32) % 2 == 0) ? 24'hFFFFFF : 24'h000000;
                endcase
                if (!e_de) e_data = 24'h0;
            end
        end
        #1;
        check("vga_data", 32'(vga_data), 32'(e_data));
        check("de", 32'(de), 32'(e_de));
        check("hs", 32'(hs), 32'(e_hs));
        check("vs", 32'(vs), 32'(e_vs));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        // Hand-computed anchors for the model itself.
        if (!rst && k == 1) check("idle_de_k1", 32'(de), 32'd0);
        if (!rst && k == 2) check("first_fs_k2", 32'({de, frame_start}), 32'b11);
        if (mv >= 0 && mv < VA && sm == 2'd0) begin
            if (mh == 0)  check("bar0", 32'(vga_data), 32'hFFFFFF);
            if (mh == 8)  check("bar1", 32'(vga_data), 32'hFFFF00);
            if (mh == 63) check("bar7", 32'(vga_data), 32'h000000);
            if (mh == 64) check("blank_after_active", 32'({de, vga_data}), 32'h0);
        end
        if (sm == 2'd1 && mh == 30 && mv == 5) check("grad_30_5", 32'(vga_data), 32'h1E0523);
        if (sm == 2'd3) begin
            if (mh == 31 && mv == 0)  check("chk_31_0", 32'(vga_data), 32'hFFFFFF);
            if (mh == 32 && mv == 0)  check("chk_32_0", 32'(vga_data), 32'h000000);
            if (mh == 32 && mv == 32) check("chk_32_32", 32'(vga_data), 32'hFFFFFF);
        end
        if (mh == 67) check("hs_before_sync", 32'(hs), 32'd1);
        if (mh == 68) check("hs_sync_start", 32'(hs), 32'd0);
        if (mh == 75) check("hs_sync_last", 32'(hs), 32'd0);
        if (mh == 76) check("hs_sync_end", 32'(hs), 32'd1);
        if (mv == 41 && mh == 79) check("vs_before_sync", 32'(vs), 32'd1);
        if (mv == 42 && mh == 0)  check("vs_sync_start", 32'(vs), 32'd0);
        if (mv >= 0 && mv < VA && mh == 10 && sm == 2'd2 && fno == 2)
            check("solid_frame2", 32'(vga_data), 32'h123456);
        if (mv >= 0 && mv < VA && mh == 10 && sm == 2'd2 && fno == 3)
            check("solid_frame3", 32'(vga_data), 32'hABCDEF);
    end

    logic [1:0]  md_pre[7] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd1, 2'd0};
    logic [23:0] cl_pre[7] = '{24'h0, 24'h55AA33, 24'h123456, 24'hABCDEF, 24'h0, 24'h0, 24'h0};
    logic [1:0]  md_post[3] = '{2'd3, 2'd0, 2'd1};

    // One frame: scramble the inputs mid-frame, restore the scheduled value before the next origin.
    task automatic run_frame(input logic [1:0] nxt_mode, input logic [23:0] nxt_color);
        repeat (FR / 2) @(negedge clk);
        mode        = 2'($urandom_range(0, 3));
        solid_color = 24'($urandom);
        repeat (FR / 2 - 100) @(negedge clk);
        mode        = nxt_mode;
        solid_color = nxt_color;
        repeat (100) @(negedge clk);
    endtask

    initial begin
        rst         = 1'b1;
        mode        = md_pre[0];
        solid_color = cl_pre[0];
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int f = 0; f < 6; f++) run_frame(md_pre[f + 1], cl_pre[f + 1]);
        // Abort a frame partway through with a 3-cycle reset.
        repeat ($urandom_range(500, 2500)) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        mode = md_post[0];
        rst  = 1'b0;
        for (int f = 0; f < 2; f++) run_frame(md_post[f + 1], 24'($urandom));
        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_pattern_timing_gen.md
# vga_pattern_timing_gen

Upstream source for the RGB888 split stage: generates VGA raster timing (hsync, vsync, data-enable) and a selectable 24-bit test pattern on `vga_data` ({R,G,B}, R in [23:16]). The pattern feeds directly into the 24-bit-to-RGB888 splitter. It is used for bring-up of displays and downstream pixel pipelines without a frame buffer. All outputs are registered and aligned to each other.

## Interface
- `H_ACTIVE`, 640, visible pixels per line; must be a multiple of 8
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level (0 = active low)
- `VS_POL`, 0, vsync active level (0 = active low)
- `clk`  in  1  pixel clock; one clock domain; reset is synchronous and active-high
- `rst`  in  1  synchronous, active-high reset
- `mode`  in  2  pattern select: 0 colour bars, 1 gradient, 2 solid, 3 checkerboard
- `solid_color`  in  24  colour for mode 2
- `vga_data`  out  24  pixel {R,G,B}; 0 whenever `de`=0
- `hs`  out  1  horizontal sync at `HS_POL`
- `vs`  out  1  vertical sync at `VS_POL`
- `de`  out  1  active-video enable
- `frame_start`  out  1  one-cycle pulse coinciding with first active pixel of each frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Counters `h_cnt` 0..H_TOTAL-1, `v_cnt` 0..V_TOTAL-1.
- `h_cnt` increments every clock and wraps to 0 after H_TOTAL-1. `v_cnt` increments only on an `h_cnt` wrap and wraps to 0 after V_TOTAL-1; a double wrap starts a new frame.
- Regions (per axis): active [0, ACTIVE-1], front porch, sync [ACTIVE+FP, ACTIVE+FP+SYNC-1], back porch.
- hs = HS_POL when `h_cnt` is in its sync range, else ~HS_POL. vs is the same on `v_cnt`, independent of `h_cnt`.
- de = h-active AND v-active.
- `mode` and `solid_color` are captured into shadow registers only when h_cnt=0 and v_cnt=0. Changes mid-frame have no effect until the next frame.
- Patterns, computed from the counters:
  - mode 0: 8 vertical bars, each BAR_W=H_ACTIVE/8 pixels wide. The bar index comes from a sub-counter reset at h_cnt=0, not a divider. Colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - mode 1: R=h_cnt[7:0], G=v_cnt[7:0], B=(h_cnt+v_cnt)[7:0] (modulo 256).
  - mode 2: shadowed `solid_color`.
  - mode 3: 32x32 checkerboard; FFFFFF if h_cnt[5]^v_cnt[5]=0, else 000000.
- frame_start = 1 for the cycle where h_cnt=0 and v_cnt=0.
- Reset values: h_cnt=0, v_cnt=0, vga_data=0, de=0, hs=~HS_POL, vs=~VS_POL, frame_start=0, shadow mode=0, shadow colour=0.
- Reset asserted mid-frame aborts the frame. Outputs take reset values on the next edge, and the raster restarts from pixel (0,0) after release.

## Timing
- Single pipeline stage: all outputs for counter state (h,v) appear one clock after the counters hold (h,v). All outputs are mutually aligned.
- On the first edge after rst deasserts, counters are at (0,0). On the following edge: de=1, frame_start=1, vga_data = pixel (0,0) under the shadow captured on that same edge.
- Shadow capture at (0,0) is visible from pixel (0,0) of that frame.
- de high for exactly H_ACTIVE consecutive cycles per active line. Each frame has V_ACTIVE such lines, and the frame period is H_TOTAL*V_TOTAL cycles (420000 at defaults).
- hs low-time H_SYNC cycles every H_TOTAL cycles. vs low-time V_SYNC*H_TOTAL cycles, with edges aligned to h_cnt=0.

## Test plan
- Reset then run 2 frames, mode=0: de rises 2 cycles after rst release. vga_data is FFFFFF for pixels 0..79, FFFF00 for 80..159, and so on, 000000 for 560..639. vga_data=0 at pixel 640.
- Sync check at defaults: hs falls at pixel 656 and rises at 752. Line period 800 cycles. vs low for 1600 cycles starting at line 490. frame_start period 420000.
- mode=1: pixel (300,5) outputs R=2C, G=05, B=31 (h+v=305 mod 256).
- mode=2 with solid_color=123456; change to ABCDEF at line 100. Remainder of the frame stays 123456; next frame is ABCDEF.
- mode=3: pixel (31,0)=FFFFFF, (32,0)=000000, (32,32)=FFFFFF.
- Assert rst for 3 cycles at line 200, pixel 300: outputs go to reset values (hs=vs=1, de=0, data=0). After release, frame_start pulses 2 cycles later and the raster restarts at (0,0).
